// File: rtl/decode_fuse_stage.sv
// Registered decoder stage: decodes address/ALU select codes and fuses runs of INC/DEC/MVR/MVL
// into one op with a repeat count. Two registers (accumulator + output), valid/ready on both sides.
module decode_fuse_stage #(
  parameter int INSTR_W  = 9,
  parameter int MAX_RUN  = 15,
  parameter int CNT_W    = $clog2(MAX_RUN + 1),
  parameter int DROP_NOP = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_op,
  output logic [2:0]         out_addr_sel,
  output logic [2:0]         out_alu_sel,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_illegal
);

  localparam logic [2:0] OP_INC = 3'd0;
  localparam logic [2:0] OP_DEC = 3'd1;
  localparam logic [2:0] OP_MVR = 3'd4;
  localparam logic [2:0] OP_MVL = 3'd5;
  localparam logic [2:0] OP_NOP = 3'd7;

  logic             acc_vld_q, acc_vld_d;
  logic [2:0]       acc_op_q, acc_op_d;
  logic [2:0]       acc_addr_q, acc_addr_d;
  logic [2:0]       acc_alu_q, acc_alu_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             acc_ill_q, acc_ill_d;

  logic             out_vld_q, out_vld_d;
  logic [2:0]       out_op_q, out_op_d;
  logic [2:0]       out_addr_q, out_addr_d;
  logic [2:0]       out_alu_q, out_alu_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_ill_q, out_ill_d;

  logic       in_ill, in_fusible, out_free, accept, merge, drop, load, move;
  logic [2:0] in_op, in_addr, in_alu;

  assign in_op      = in_instr[2:0];
  assign in_ill     = |in_instr[INSTR_W-1:3];
  assign in_fusible = (in_op == OP_INC) || (in_op == OP_DEC) ||
                      (in_op == OP_MVR) || (in_op == OP_MVL);

  always_comb begin
    in_addr = 3'd0;
    in_alu  = 3'd0;
    if (!in_ill) begin
      case (in_op)
        3'd2, 3'd3: begin in_addr = 3'd1; in_alu = 3'd2; end
        3'd4, 3'd5: begin in_addr = 3'd0; in_alu = 3'd1; end
        3'd6, 3'd7: begin in_addr = 3'd2; in_alu = 3'd3; end
        default:    begin in_addr = 3'd0; in_alu = 3'd0; end
      endcase
    end
  end

  assign out_free = !out_vld_q || out_ready;
  assign in_ready = !acc_vld_q || out_free;
  assign accept   = in_valid && in_ready;
  assign merge    = accept && acc_vld_q && in_fusible && (in_op == acc_op_q) &&
                    !acc_ill_q && !in_ill && (acc_cnt_q < CNT_W'(MAX_RUN));
  // A dropped NOP is consumed but leaves the accumulator alone, so it never splits a run.
  assign drop     = accept && (DROP_NOP != 0) && !in_ill && (in_op == OP_NOP);
  assign load     = accept && !merge && !drop;
  assign move     = acc_vld_q && out_free && !merge && !drop;

  always_comb begin
    acc_vld_d  = acc_vld_q;
    acc_op_d   = acc_op_q;
    acc_addr_d = acc_addr_q;
    acc_alu_d  = acc_alu_q;
    acc_cnt_d  = acc_cnt_q;
    acc_ill_d  = acc_ill_q;
    if (merge) begin
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end else if (load) begin
      acc_vld_d  = 1'b1;
      acc_op_d   = in_op;
      acc_addr_d = in_addr;
      acc_alu_d  = in_alu;
      acc_cnt_d  = CNT_W'(1);
      acc_ill_d  = in_ill;
    end else if (move) begin
      acc_vld_d = 1'b0;
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q;
    out_op_d   = out_op_q;
    out_addr_d = out_addr_q;
    out_alu_d  = out_alu_q;
    out_cnt_d  = out_cnt_q;
    out_ill_d  = out_ill_q;
    if (move) begin
      out_vld_d  = 1'b1;
      out_op_d   = acc_op_q;
      out_addr_d = acc_addr_q;
      out_alu_d  = acc_alu_q;
      out_cnt_d  = acc_cnt_q;
      out_ill_d  = acc_ill_q;
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      acc_vld_q  <= 1'b0;
      acc_op_q   <= 3'd0;
      acc_addr_q <= 3'd0;
      acc_alu_q  <= 3'd0;
      acc_cnt_q  <= '0;
      acc_ill_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_op_q   <= 3'd0;
      out_addr_q <= 3'd0;
      out_alu_q  <= 3'd0;
      out_cnt_q  <= '0;
      out_ill_q  <= 1'b0;
    end else begin
      acc_vld_q  <= acc_vld_d;
      acc_op_q   <= acc_op_d;
      acc_addr_q <= acc_addr_d;
      acc_alu_q  <= acc_alu_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_ill_q  <= acc_ill_d;
      out_vld_q  <= out_vld_d;
      out_op_q   <= out_op_d;
      out_addr_q <= out_addr_d;
      out_alu_q  <= out_alu_d;
      out_cnt_q  <= out_cnt_d;
      out_ill_q  <= out_ill_d;
    end
  end

  assign out_valid    = out_vld_q;
  assign out_op       = out_op_q;
  assign out_addr_sel = out_addr_q;
  assign out_alu_sel  = out_alu_q;
  assign out_count    = out_cnt_q;
  assign out_illegal  = out_ill_q;

endmodule

// File: tb/tb_decode_fuse_stage.sv
// Directed bench for decode_fuse_stage: cycle table on the DROP_NOP=0 instance, hand sequences
// for saturation, backpressure, NOP dropping and flush on the DROP_NOP=1 instance.
module tb_decode_fuse_stage;

  logic       clock = 1'b0;
  logic       reset, flush, in_valid, out_ready;
  logic [8:0] in_instr;

  logic       irdy0, ovld0, ill0, irdy1, ovld1, ill1;
  logic [2:0] op0, addr0, alu0, op1, addr1, alu1;
  logic [3:0] cnt0, cnt1;

  always #5 clock = ~clock;

  decode_fuse_stage #(.INSTR_W(9), .MAX_RUN(15), .DROP_NOP(0)) u0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irdy0),
    .in_instr(in_instr), .out_valid(ovld0), .out_ready(out_ready), .out_op(op0),
    .out_addr_sel(addr0), .out_alu_sel(alu0), .out_count(cnt0), .out_illegal(ill0));

  decode_fuse_stage #(.INSTR_W(9), .MAX_RUN(15), .DROP_NOP(1)) u1 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irdy1),
    .in_instr(in_instr), .out_valid(ovld1), .out_ready(out_ready), .out_op(op1),
    .out_addr_sel(addr1), .out_alu_sel(alu1), .out_count(cnt1), .out_illegal(ill1));

  // Monitored instance select and its outputs
  logic       sel;
  logic       s_irdy, s_ovld, s_ill;
  logic [2:0] s_op, s_addr, s_alu;
  logic [3:0] s_cnt;

  always_comb begin
    s_irdy = sel ? irdy1 : irdy0;
    s_ovld = sel ? ovld1 : ovld0;
    s_op   = sel ? op1   : op0;
    s_addr = sel ? addr1 : addr0;
    s_alu  = sel ? alu1  : alu0;
    s_cnt  = sel ? cnt1  : cnt0;
    s_ill  = sel ? ill1  : ill0;
  end

  typedef struct {
    logic        v;
    logic [8:0]  instr;
    logic        ordy;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] xfer[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic add(input logic v, input logic [8:0] ins, input logic ordy, input logic irdy,
                     input logic ovld, input logic [2:0] op, input logic [3:0] cnt,
                     input logic [2:0] addr, input logic [2:0] alu, input logic ill);
    vec_t t;
    t.v = v; t.instr = ins; t.ordy = ordy;
    t.exp = ovld ? {irdy, 1'b1, op, cnt, addr, alu, ill} : {irdy, 1'b0, 14'd0};
    vecs.push_back(t);
  endtask

  // Drive inputs mid-cycle, then sample; record any handshake completing this cycle
  task automatic apply(input logic v, input logic [8:0] ins, input logic ordy, input logic fl);
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    #1;
    if (s_ovld && ordy) xfer.push_back({s_op, s_cnt, s_addr, s_alu, s_ill});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] got_vec();
    return s_ovld ? {s_irdy, 1'b1, s_op, s_cnt, s_addr, s_alu, s_ill} : {s_irdy, 1'b0, 14'd0};
  endfunction

  initial begin
    sel = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0; in_instr = '0; out_ready = 1'b1; flush = 1'b0;

    // Reset while an instruction is offered: it must be discarded
    #1;
    apply(1'b1, 9'h000, 1'b1, 1'b0);
    tick(); tick(); tick();
    reset = 1'b0;
    apply(1'b0, 9'h000, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #0;
      chk("reset_state", {16'd0, s_irdy, s_ovld, s_op, s_cnt, s_addr, s_alu, s_ill},
          {16'd0, 1'b1, 15'd0});
    end
    sel = 1'b0;
    tick();
    xfer.delete();

    // v, instr, ordy | in_ready, out_valid, op, count, addr, alu, illegal
    add(1, 9'h000, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9'h000, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9'h000, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 9'h000, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 9'h000, 1, 1, 1, 0, 3, 0, 0, 0);
    add(1, 9'h002, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9'h002, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9'h006, 1, 1, 1, 2, 1, 1, 2, 0);
    add(1, 9'h000, 1, 1, 1, 2, 1, 1, 2, 0);
    add(1, 9'h001, 1, 1, 1, 6, 1, 2, 3, 0);
    add(1, 9'h000, 1, 1, 1, 0, 1, 0, 0, 0);
    add(1, 9'h008, 1, 1, 1, 1, 1, 0, 0, 0);
    add(1, 9'h000, 1, 1, 1, 0, 1, 0, 0, 0);
    add(0, 9'h000, 1, 1, 1, 0, 1, 0, 0, 1);
    add(0, 9'h000, 1, 1, 1, 0, 1, 0, 0, 0);
    add(0, 9'h000, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9'h003, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9'h005, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9'h005, 1, 1, 1, 3, 1, 1, 2, 0);
    add(0, 9'h000, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 9'h000, 1, 1, 1, 5, 2, 0, 1, 0);
    add(1, 9'h007, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 9'h000, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 9'h000, 1, 1, 1, 7, 1, 2, 3, 0);
    add(0, 9'h000, 1, 1, 0, 0, 0, 0, 0, 0);
    // Backpressure: two groups pending, outputs held, then drain in order
    add(1, 9'h000, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9'h001, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 9'h001, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 9'h001, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 9'h001, 1, 1, 1, 0, 1, 0, 0, 0);
    add(0, 9'h000, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 9'h000, 1, 1, 1, 1, 2, 0, 0, 0);
    add(0, 9'h000, 1, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].v, vecs[i].instr, vecs[i].ordy, 1'b0);
      if (got_vec() !== vecs[i].exp)
        $display("FAIL vec%0d: got 0x%0h expected 0x%0h", i, got_vec(), vecs[i].exp);
      n_chk++;
      if (got_vec() === vecs[i].exp) n_pass++;
      tick();
    end

    // Saturation: 20 contiguous MVR split into 15 + 5
    xfer.delete();
    for (int i = 0; i < 20; i++) begin apply(1'b1, 9'h004, 1'b1, 1'b0); tick(); end
    for (int i = 0; i < 6; i++)  begin apply(1'b0, 9'h000, 1'b1, 1'b0); tick(); end
    chk("sat_count", xfer.size(), 2);
    if (xfer.size() == 2) begin
      chk("sat_first",  {18'd0, xfer[0]}, {18'd0, 3'd4, 4'd15, 3'd0, 3'd1, 1'b0});
      chk("sat_second", {18'd0, xfer[1]}, {18'd0, 3'd4, 4'd5, 3'd0, 3'd1, 1'b0});
    end

    // NOP dropping keeps the run intact
    sel = 1'b1;
    #0;
    xfer.delete();
    apply(1'b1, 9'h000, 1'b1, 1'b0); tick();
    apply(1'b1, 9'h007, 1'b1, 1'b0); tick();
    apply(1'b1, 9'h000, 1'b1, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin apply(1'b0, 9'h000, 1'b1, 1'b0); tick(); end
    chk("dropnop_count", xfer.size(), 1);
    if (xfer.size() == 1)
      chk("dropnop_out", {18'd0, xfer[0]}, {18'd0, 3'd0, 4'd2, 3'd0, 3'd0, 1'b0});

    // Flush with an output pending and a partial group in the accumulator
    xfer.delete();
    apply(1'b1, 9'h002, 1'b0, 1'b0); tick();
    apply(1'b1, 9'h000, 1'b0, 1'b0); tick();
    apply(1'b1, 9'h000, 1'b0, 1'b0);
    chk("stall_in_ready", {31'd0, s_irdy}, 32'd0);
    tick();
    apply(1'b1, 9'h000, 1'b0, 1'b1);
    chk("preflush_valid", {31'd0, s_ovld}, 32'd1);
    tick();
    apply(1'b0, 9'h000, 1'b1, 1'b0);
    chk("postflush_state", {16'd0, s_irdy, s_ovld, s_op, s_cnt, s_addr, s_alu, s_ill},
        {16'd0, 1'b1, 15'd0});
    tick();
    for (int i = 0; i < 4; i++) begin apply(1'b0, 9'h000, 1'b1, 1'b0); tick(); end
    chk("postflush_none", xfer.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
